// File: rtl/cpu6502_pkg.sv
// Shared widths and reset defaults for the 6502 datapath blocks.
package cpu6502_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;
    localparam logic [ADDR_W-1:0] RESET_AB_DEFAULT = 16'h0000;

    // Join a high and low byte into a full address.
    function automatic logic [ADDR_W-1:0] make_addr(input logic [BYTE_W-1:0] hi,
                                                    input logic [BYTE_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/pc_half.sv
// One byte of the program counter: select mux (bus or self), incrementer
// with carry-in/carry-out, and the holding register.
module pc_half
    import cpu6502_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rdy,
    input  logic [BYTE_W-1:0] reset_val,
    input  logic [BYTE_W-1:0] bus,
    input  logic              sel,
    input  logic              cin,
    output logic [BYTE_W-1:0] q,
    output logic              cout
);

    logic [BYTE_W-1:0] sel_val;
    logic [BYTE_W:0]   sum;

    // Pick the loaded bus byte or recirculate the register, then add the carry-in.
    always_comb begin
        sel_val = sel ? bus : q;
        sum     = {1'b0, sel_val} + {{BYTE_W{1'b0}}, cin};
    end

    assign cout = sum[BYTE_W];

    // Register the incremented byte; RDY low freezes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= reset_val;
        else if (rdy)
            q <= sum[BYTE_W-1:0];
    end

endmodule

// File: rtl/pc_address_unit.sv
// Program counter (PCL/PCH) and address bus latches (ABL/ABH) of the 6502.
// All outputs come straight from registers so the loop through the bus
// routing stage is always broken by a clock edge.
module pc_address_unit
    import cpu6502_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_AB = RESET_AB_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rdy,
    input  logic [BYTE_W-1:0] i_bus_adl,
    input  logic [BYTE_W-1:0] i_bus_adh,
    input  logic              i_adl_pcl,
    input  logic              i_adh_pch,
    input  logic              i_i_pc,
    input  logic              i_adl_abl,
    input  logic              i_adh_abh,
    output logic [BYTE_W-1:0] o_pcl,
    output logic [BYTE_W-1:0] o_pch,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_pcl_carry
);

    logic              pcl_cout;
    logic              pch_cout;
    logic [BYTE_W-1:0] abl;
    logic [BYTE_W-1:0] abh;

    pc_half u_pcl (
        .clk       (i_clk),
        .reset     (i_reset),
        .rdy       (i_rdy),
        .reset_val (RESET_PC[BYTE_W-1:0]),
        .bus       (i_bus_adl),
        .sel       (i_adl_pcl),
        .cin       (i_i_pc),
        .q         (o_pcl),
        .cout      (pcl_cout)
    );

    // High byte takes the low byte's carry in the same cycle; its own carry is dropped (wrap).
    pc_half u_pch (
        .clk       (i_clk),
        .reset     (i_reset),
        .rdy       (i_rdy),
        .reset_val (RESET_PC[ADDR_W-1:BYTE_W]),
        .bus       (i_bus_adh),
        .sel       (i_adh_pch),
        .cin       (pcl_cout),
        .q         (o_pch),
        .cout      (pch_cout)
    );

    // Address bus latches and the debug copy of the PCL carry.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            abl         <= RESET_AB[BYTE_W-1:0];
            abh         <= RESET_AB[ADDR_W-1:BYTE_W];
            o_pcl_carry <= 1'b0;
        end else if (i_rdy) begin
            if (i_adl_abl)
                abl <= i_bus_adl;
            if (i_adh_abh)
                abh <= i_bus_adh;
            o_pcl_carry <= pcl_cout;
        end
    end

    assign o_address = make_addr(abh, abl);

    logic unused_pch_cout;
    assign unused_pch_cout = pch_cout;

endmodule

// File: tb/tb_pc_address_unit.sv
// Bench for pc_address_unit: vector table, hand sequences for reset and
// stall, then randomized traffic against a 16-bit arithmetic model.
module tb_pc_address_unit;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [7:0]  adl;
    logic [7:0]  adh;
    logic        adl_pcl;
    logic        adh_pch;
    logic        inc;
    logic        adl_abl;
    logic        adh_abh;
    logic [7:0]  pcl;
    logic [7:0]  pch;
    logic [15:0] address;
    logic        carry;

    int checks;
    int errors;

    pc_address_unit dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rdy       (rdy),
        .i_bus_adl   (adl),
        .i_bus_adh   (adh),
        .i_adl_pcl   (adl_pcl),
        .i_adh_pch   (adh_pch),
        .i_i_pc      (inc),
        .i_adl_abl   (adl_abl),
        .i_adh_abh   (adh_abh),
        .o_pcl       (pcl),
        .o_pch       (pch),
        .o_address   (address),
        .o_pcl_carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  adl;
        logic [7:0]  adh;
        logic        adl_pcl;
        logic        adh_pch;
        logic        inc;
        logic        adl_abl;
        logic        adh_abh;
        logic [15:0] exp_pc;
        logic [15:0] exp_addr;
        logic        exp_c;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [15:0] e_pc,
                           input logic [15:0] e_addr, input logic e_c);
        chk({name, " pc"}, {pch, pcl}, e_pc);
        chk({name, " addr"}, address, e_addr);
        chk({name, " carry"}, {15'd0, carry}, {15'd0, e_c});
    endtask

    task automatic drive(input logic [7:0] a_l, input logic [7:0] a_h, input logic s_l,
                         input logic s_h, input logic i, input logic ab_l, input logic ab_h);
        adl = a_l; adh = a_h; adl_pcl = s_l; adh_pch = s_h;
        inc = i; adl_abl = ab_l; adh_abh = ab_h;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model state: whole PC as one 16-bit number.
    logic [15:0] m_pc;
    logic [15:0] m_ab;
    logic        m_c;

    task automatic model_step;
        logic [15:0] base;
        logic [16:0] sum;
        if (rst) begin
            m_pc = 16'h0000; m_ab = 16'h0000; m_c = 1'b0;
        end else if (rdy) begin
            base = {adh_pch ? adh : m_pc[15:8], adl_pcl ? adl : m_pc[7:0]};
            sum  = {1'b0, base} + {16'd0, inc};
            m_c  = inc && (base[7:0] == 8'hFF);
            m_pc = sum[15:0];
            if (adl_abl) m_ab[7:0]  = adl;
            if (adh_abh) m_ab[15:8] = adh;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //                adl    adh    sl sh inc abl abh  pc        addr      c
        vecs[0]  = '{8'hFC, 8'hFF, 1, 1, 0, 0, 0, 16'hFFFC, 16'h0000, 0};
        vecs[1]  = '{8'h00, 8'h00, 0, 0, 1, 0, 0, 16'hFFFD, 16'h0000, 0};
        vecs[2]  = '{8'h00, 8'h00, 0, 0, 1, 0, 0, 16'hFFFE, 16'h0000, 0};
        vecs[3]  = '{8'h00, 8'h00, 0, 0, 1, 0, 0, 16'hFFFF, 16'h0000, 0};
        vecs[4]  = '{8'h00, 8'h00, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1};
        vecs[5]  = '{8'hFF, 8'h12, 1, 1, 0, 0, 0, 16'h12FF, 16'h0000, 0};
        vecs[6]  = '{8'h00, 8'h00, 0, 0, 1, 0, 0, 16'h1300, 16'h0000, 1};
        vecs[7]  = '{8'h34, 8'h80, 1, 1, 1, 0, 0, 16'h8035, 16'h0000, 0};
        vecs[8]  = '{8'hAA, 8'h55, 0, 0, 0, 1, 1, 16'h8035, 16'h55AA, 0};
        vecs[9]  = '{8'h01, 8'h77, 0, 0, 0, 1, 0, 16'h8035, 16'h5501, 0};
        // ADL carries the current PCL: ABL sees the pre-edge value while PC advances.
        vecs[10] = '{8'h35, 8'h00, 0, 0, 1, 1, 0, 16'h8036, 16'h5535, 0};
        vecs[11] = '{8'hFF, 8'hFF, 1, 1, 1, 0, 0, 16'h0000, 16'h5535, 1};

        rst = 1'b1;
        rdy = 1'b1;
        drive(8'h00, 8'h00, 0, 0, 0, 0, 0);
        tick;
        chk_all("reset", 16'h0000, 16'h0000, 1'b0);
        rst = 1'b0;

        // Reset arriving mid-operation clears state without a clock edge.
        drive(8'hFF, 8'h12, 1, 1, 0, 1, 1);
        tick;
        chk_all("preload", 16'h12FF, 16'h12FF, 1'b0);
        drive(8'h00, 8'h00, 0, 0, 1, 0, 0);
        tick;
        chk_all("pre-reset", 16'h1300, 16'h12FF, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async reset", 16'h0000, 16'h0000, 1'b0);
        tick;
        rst = 1'b0;
        drive(8'h00, 8'h00, 0, 0, 0, 0, 0);
        tick;
        chk_all("post-reset", 16'h0000, 16'h0000, 1'b0);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].adl, vecs[i].adh, vecs[i].adl_pcl, vecs[i].adh_pch,
                  vecs[i].inc, vecs[i].adl_abl, vecs[i].adh_abh);
            tick;
            chk_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_addr, vecs[i].exp_c);
        end

        // Stall: everything asserted but RDY low, nothing may move (carry held at 1).
        rdy = 1'b0;
        drive(8'h9A, 8'hBC, 1, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_all($sformatf("stall%0d", i), 16'h0000, 16'h5535, 1'b1);
        end
        rdy = 1'b1;
        drive(8'h9A, 8'hBC, 0, 0, 1, 0, 0);
        tick;
        chk_all("unstall", 16'h0001, 16'h5535, 1'b0);

        // Randomized traffic against the model.
        m_pc = 16'h0001; m_ab = 16'h5535; m_c = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 255), $urandom_range(0, 255),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) adl = pcl;
            if ($urandom_range(0, 7) == 0) begin adl = 8'hFF; adl_pcl = 1'b1; inc = 1'b1; end
            model_step;
            tick;
            rst = 1'b0;
            chk_all($sformatf("rand%0d", i), m_pc, m_ab, m_c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
